// File: rtl/branch_ctrl_pkg.sv
// ============================================================================
// Module  : branch_ctrl_pkg
// Brief   : Types and constants for the branch predictor / redirect controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_ctrl_pkg;

    // Tag and target fields are stored at the widest supported PC width.
    localparam int BC_MAX_DW = 32;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } bc_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 uncond;
        logic [1:0]           ctr;
        logic [BC_MAX_DW-1:0] tag;
        logic [BC_MAX_DW-1:0] target;
    } bht_entry_t;

    localparam bht_entry_t BHT_RESET = '{valid: 1'b0, uncond: 1'b0, ctr: WNT,
                                         tag: '0, target: '0};

endpackage

`default_nettype wire

// File: rtl/cfu_pkg.sv
// ============================================================================
// Module  : cfu_pkg
// Brief   : Control-flow unit operation encoding shared across the pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cfu_pkg;

    typedef enum logic [3:0] {
        NB   = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BLT  = 4'd3,
        BGE  = 4'd4,
        BLTU = 4'd5,
        BGEU = 4'd6,
        JAL  = 4'd7,
        JALR = 4'd8
    } cfuop_t;

endpackage

`default_nettype wire

// File: rtl/branch_ctrl_bht.sv
// ============================================================================
// Module  : branch_ctrl_bht
// Brief   : Direct-mapped history/target table, two async read ports, one write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_ctrl_bht
    import branch_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX-1:0]   i_rd0_idx,
    output bht_entry_t       o_rd0_entry,
    input  logic [IDX-1:0]   i_rd1_idx,
    output bht_entry_t       o_rd1_entry,
    input  logic             i_wr_en,
    input  logic [IDX-1:0]   i_wr_idx,
    input  bht_entry_t       i_wr_entry
);

    bht_entry_t r_mem [ENTRIES];

    // Reads return pre-write contents; a write lands at the clock edge.
    assign o_rd0_entry = r_mem[i_rd0_idx];
    assign o_rd1_entry = r_mem[i_rd1_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_entry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// Module  : branch_ctrl
// Brief   : Fetch-time branch prediction, EX-time check/training, redirect FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_ctrl
    import cfu_pkg::*;
    import branch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  cfuop_t                ex_cfuop,
    input  logic                  ex_br_taken,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_pred_target,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic [31:0]           mispred_cnt
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    bc_state_t             r_state;
    bc_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic [31:0]           r_mispred_cnt;

    logic [IDX-1:0]        w_f_idx;
    logic [IDX-1:0]        w_ex_idx;
    logic [BC_MAX_DW-1:0]  w_f_tag;
    logic [BC_MAX_DW-1:0]  w_ex_tag;
    bht_entry_t            w_f_ent;
    bht_entry_t            w_ex_ent;
    logic                  w_f_hit;
    logic                  w_ex_hit;
    logic                  w_resolve;
    logic                  w_mispred;
    logic [DATA_WIDTH-1:0] w_correct_pc;
    logic                  w_wr_en;
    bht_entry_t            w_wr_ent;
    logic [1:0]            w_ctr_base;
    logic                  w_unused;

    assign w_f_idx  = if_pc[IDX+1:2];
    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_f_tag  = BC_MAX_DW'(if_pc[DATA_WIDTH-1:IDX+2]);
    assign w_ex_tag = BC_MAX_DW'(ex_pc[DATA_WIDTH-1:IDX+2]);
    assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

    branch_ctrl_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX     (IDX)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .i_rd0_idx   (w_f_idx),
        .o_rd0_entry (w_f_ent),
        .i_rd1_idx   (w_ex_idx),
        .o_rd1_entry (w_ex_ent),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_ex_idx),
        .i_wr_entry  (w_wr_ent)
    );

    assign w_f_hit     = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
    assign pred_taken  = w_f_hit && (w_f_ent.ctr[1] || w_f_ent.uncond);
    assign pred_target = pred_taken ? w_f_ent.target[DATA_WIDTH-1:0]
                                    : if_pc + DATA_WIDTH'(4);

    // Wrong-path EX contents during REDIRECT/DRAIN never reach the check.
    assign w_resolve = (r_state == S_IDLE) && ex_valid && !ex_stall;
    assign w_ex_hit  = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);

    assign w_mispred = w_resolve &&
        ((ex_cfuop == NB) ? ex_pred_taken
                          : ((ex_br_taken != ex_pred_taken) ||
                             (ex_br_taken && (ex_target != ex_pred_target))));

    assign w_correct_pc = ex_br_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
    assign w_ctr_base   = w_ex_hit ? w_ex_ent.ctr : WNT;

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ent = w_ex_ent;
        if (w_resolve) begin
            case (ex_cfuop)
                JAL, JALR: begin
                    w_wr_en         = 1'b1;
                    w_wr_ent.valid  = 1'b1;
                    w_wr_ent.uncond = 1'b1;
                    w_wr_ent.ctr    = ST;
                    w_wr_ent.tag    = w_ex_tag;
                    w_wr_ent.target = BC_MAX_DW'(ex_target);
                end
                BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                    w_wr_en         = 1'b1;
                    w_wr_ent.valid  = 1'b1;
                    w_wr_ent.uncond = 1'b0;
                    w_wr_ent.tag    = w_ex_tag;
                    if (!w_ex_hit || ex_br_taken) begin
                        w_wr_ent.target = BC_MAX_DW'(ex_target);
                    end
                    if (ex_br_taken) begin
                        w_wr_ent.ctr = (w_ctr_base == ST) ? ST : w_ctr_base + 2'd1;
                    end else begin
                        w_wr_ent.ctr = (w_ctr_base == SNT) ? SNT : w_ctr_base - 2'd1;
                    end
                end
                NB: begin
                    if (w_ex_hit) begin
                        w_wr_en        = 1'b1;
                        w_wr_ent.valid = 1'b0;
                    end
                end
                default: w_wr_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        redirect    = 1'b0;
        flush       = 1'b0;
        case (r_state)
            S_IDLE:     if (w_mispred) w_state_nxt = S_REDIRECT;
            S_REDIRECT: begin
                redirect    = 1'b1;
                flush       = 1'b1;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                flush       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_redirect_pc <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mispred) begin
                r_redirect_pc <= w_correct_pc;
                if (r_mispred_cnt != 32'hFFFF_FFFF) begin
                    r_mispred_cnt <= r_mispred_cnt + 32'd1;
                end
            end
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign mispred_cnt = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module  : tb_branch_ctrl
// Brief   : Self-checking bench: directed vector table, corner sequences, random.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;
    import cfu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    cfuop_t      ex_cfuop;
    logic        ex_br_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_ctrl #(.DATA_WIDTH(32), .BHT_ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_pc          (ex_pc),
        .ex_cfuop       (ex_cfuop),
        .ex_br_taken    (ex_br_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: table as plain arrays, pipeline phase as 0/1/2 (idle/redirect/drain).
    bit          mv [16];
    bit          mu [16];
    int          mc [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          m_phase;
    logic [31:0] m_rpc;
    logic [31:0] m_cnt;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mu[i] = 0; mc[i] = 1; mtag[i] = 0; mtgt[i] = 0;
        end
        m_phase = 0; m_rpc = 0; m_cnt = 0;
    endtask

    function automatic logic [32:0] m_lookup(input logic [31:0] pc);
        int i = int'(pc[5:2]);
        if (mv[i] && mtag[i] == (pc >> 6) && (mc[i] >= 2 || mu[i]))
            return {1'b1, mtgt[i]};
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic m_train();
        int  i   = int'(ex_pc[5:2]);
        bit  hit = mv[i] && mtag[i] == (ex_pc >> 6);
        case (ex_cfuop)
            NB: if (hit) mv[i] = 0;
            JAL, JALR: begin
                mv[i] = 1; mu[i] = 1; mc[i] = 3; mtag[i] = ex_pc >> 6; mtgt[i] = ex_target;
            end
            default: begin
                if (!hit) begin
                    mv[i] = 1; mtag[i] = ex_pc >> 6; mc[i] = 1; mtgt[i] = ex_target;
                end
                mu[i] = 0;
                if (ex_br_taken) begin
                    mc[i] = (mc[i] + 1 > 3) ? 3 : mc[i] + 1;
                    mtgt[i] = ex_target;
                end else begin
                    mc[i] = (mc[i] - 1 < 0) ? 0 : mc[i] - 1;
                end
            end
        endcase
    endtask

    task automatic m_step();
        bit mis;
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) m_phase = 0;
        else if (ex_valid && !ex_stall) begin
            if (ex_cfuop == NB) mis = ex_pred_taken;
            else mis = (ex_br_taken != ex_pred_taken) ||
                       (ex_br_taken && ex_target != ex_pred_target);
            if (mis) begin
                m_phase = 1;
                m_rpc   = ex_br_taken ? ex_target : ex_pc + 32'd4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            m_train();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [32:0] p = m_lookup(if_pc);
        chk("m.pred_taken", 32'(pred_taken), 32'(p[32]));
        chk("m.pred_target", pred_target, p[31:0]);
        chk("m.redirect", 32'(redirect), 32'(m_phase == 1));
        chk("m.flush", 32'(flush), 32'(m_phase != 0));
        chk("m.redirect_pc", redirect_pc, m_rpc);
        chk("m.mispred_cnt", mispred_cnt, m_cnt);
    endtask

    // Called at posedge+1 (or +2) with inputs already driven.
    task automatic tick();
        #3;
        chk_model();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input cfuop_t op, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_cfuop = op; ex_pc = pc; ex_br_taken = tk;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    typedef struct {
        cfuop_t      op;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] cnt;
        logic        lpt;
        logic [31:0] ltgt;
    } vec_t;

    vec_t vt [11];
    logic [31:0] pcs  [8];
    logic [31:0] tgts [4];

    initial begin
        vt[0]  = '{BEQ,  32'h100, 1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h80,  32'd1, 1'b1, 32'h80};
        vt[1]  = '{NB,   32'h100, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h104, 32'd2, 1'b0, 32'h104};
        vt[2]  = '{BNE,  32'h40,  1'b1, 32'h20,  1'b0, 32'h44,  1'b1, 32'h20,  32'd3, 1'b1, 32'h20};
        vt[3]  = '{BNE,  32'h40,  1'b1, 32'h20,  1'b1, 32'h20,  1'b0, 32'h0,   32'd3, 1'b1, 32'h20};
        vt[4]  = '{BNE,  32'h40,  1'b0, 32'h20,  1'b1, 32'h20,  1'b1, 32'h44,  32'd4, 1'b1, 32'h20};
        vt[5]  = '{BNE,  32'h40,  1'b0, 32'h20,  1'b1, 32'h20,  1'b1, 32'h44,  32'd5, 1'b0, 32'h44};
        vt[6]  = '{BNE,  32'h40,  1'b0, 32'h20,  1'b0, 32'h44,  1'b0, 32'h0,   32'd5, 1'b0, 32'h44};
        vt[7]  = '{BNE,  32'h40,  1'b0, 32'h20,  1'b0, 32'h44,  1'b0, 32'h0,   32'd5, 1'b0, 32'h44};
        vt[8]  = '{BNE,  32'h40,  1'b1, 32'h20,  1'b0, 32'h44,  1'b1, 32'h20,  32'd6, 1'b0, 32'h44};
        vt[9]  = '{JALR, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300, 32'd7, 1'b1, 32'h300};
        vt[10] = '{JALR, 32'h200, 1'b1, 32'h310, 1'b1, 32'h300, 1'b1, 32'h310, 32'd8, 1'b1, 32'h310};
        pcs  = '{32'h40, 32'h100, 32'h200, 32'h500, 32'h104, 32'h1104, 32'h3c, 32'h2008};
        tgts = '{32'h80, 32'h300, 32'h310, 32'h1000};

        rst = 1'b1; m_reset();
        if_pc = 32'h100;
        ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0; ex_cfuop = NB;
        ex_br_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("rst.pred_target", pred_target, 32'h104);
        chk("rst.mispred_cnt", mispred_cnt, 32'd0);
        chk("rst.redirect", 32'(redirect), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        @(posedge clk); #1;

        for (int k = 0; k < 11; k++) begin
            drive(vt[k].op, vt[k].pc, vt[k].tk, vt[k].tgt, vt[k].pt, vt[k].ptgt);
            if_pc = 32'h3c;
            tick();
            ex_valid = 1'b0;
            #1;
            chk("vec.redirect", 32'(redirect), 32'(vt[k].mis));
            chk("vec.flush_n1", 32'(flush), 32'(vt[k].mis));
            if (vt[k].mis) chk("vec.redirect_pc", redirect_pc, vt[k].rpc);
            chk("vec.mispred_cnt", mispred_cnt, vt[k].cnt);
            tick();
            #1;
            chk("vec.flush_n2", 32'(flush), 32'(vt[k].mis));
            chk("vec.redirect_n2", 32'(redirect), 32'd0);
            tick();
            if_pc = vt[k].pc;
            #1;
            chk("vec.lookup_taken", 32'(pred_taken), 32'(vt[k].lpt));
            chk("vec.lookup_target", pred_target, vt[k].ltgt);
            tick();
        end

        // Stalled resolve: BEQ 0x500 mispredict, held 3 cycles.
        drive(BEQ, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
        ex_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall.redirect", 32'(redirect), 32'd0);
            chk("stall.cnt", mispred_cnt, 32'd8);
            tick();
        end
        ex_stall = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("stall.redirect_rel", 32'(redirect), 32'd1);
        chk("stall.cnt_once", mispred_cnt, 32'd9);
        chk("stall.redirect_pc", redirect_pc, 32'h600);
        tick();
        tick();
        tick();
        if_pc = 32'h500;
        #1;
        chk("stall.lookup", 32'(pred_taken), 32'd1);
        chk("stall.cnt_after", mispred_cnt, 32'd9);
        tick();

        // Reset pulsed mid-DRAIN.
        drive(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        ex_valid = 1'b0;
        tick();
        #1;
        chk("drain.flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstdrain.flush", 32'(flush), 32'd0);
        chk("rstdrain.redirect", 32'(redirect), 32'd0);
        chk("rstdrain.redirect_pc", redirect_pc, 32'd0);
        chk("rstdrain.cnt", mispred_cnt, 32'd0);
        m_reset();
        #1 rst = 1'b0;
        tick();

        // Random traffic against the model.
        for (int r = 0; r < 600; r++) begin
            logic [32:0] p;
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_stall = ($urandom_range(0, 3) == 0);
            ex_cfuop = cfuop_t'(4'($urandom_range(0, 8)));
            ex_pc    = pcs[$urandom_range(0, 7)];
            if_pc    = pcs[$urandom_range(0, 7)];
            ex_br_taken = (ex_cfuop == JAL || ex_cfuop == JALR) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_target = tgts[$urandom_range(0, 3)];
            p = m_lookup(ex_pc);
            if ($urandom_range(0, 3) != 0) begin
                ex_pred_taken = p[32]; ex_pred_target = p[31:0];
            end else begin
                ex_pred_taken = 1'($urandom_range(0, 1));
                ex_pred_target = tgts[$urandom_range(0, 3)];
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
